// File: rtl/level_sequencer.sv
// Level sequencer: title, play, death and respawn flow for the platformer.
// Holds the death screen for a number of frame ticks and tracks per-level save points.
module level_sequencer #(
   parameter int unsigned BRICK        = 20,
   parameter int unsigned DEATH_FRAMES = 60,
   parameter int unsigned EXIT_X       = 620,
   parameter int unsigned MARIO_H      = 24
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic       start_key,
   input  logic [9:0] mario_pos_x,
   input  logic [9:0] mario_pos_y,
   input  logic       mario_dead,
   output logic [1:0] level_sel,
   output logic [1:0] bg_index,
   output logic [9:0] spawn_x,
   output logic [9:0] spawn_y,
   output logic       respawn,
   output logic       engine_reset,
   output logic [1:0] saved,
   output logic [7:0] death_count
);

   localparam int unsigned CNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

   localparam logic [2:0] S_TITLE   = 3'd0;
   localparam logic [2:0] S_PLAY1   = 3'd1;
   localparam logic [2:0] S_PLAY2   = 3'd2;
   localparam logic [2:0] S_DEATH   = 3'd3;
   localparam logic [2:0] S_RESPAWN = 3'd4;

   localparam logic [1:0] LVL_TITLE = 2'd0;
   localparam logic [1:0] LVL_1     = 2'd1;
   localparam logic [1:0] LVL_2     = 2'd2;
   localparam logic [1:0] LVL_DEATH = 2'd3;

   localparam logic [9:0] HOME_X  = 10'd20;
   localparam logic [9:0] HOME_Y  = 10'd336;
   localparam logic [9:0] SAVE1_X = 10'd60;
   localparam logic [9:0] SAVE1_Y = 10'd376;
   localparam logic [9:0] SAVE2_X = 10'd560;
   localparam logic [9:0] SAVE2_Y = 10'd276;

   localparam logic [10:0] SAVE1_X_LO  = 11'(3 * BRICK);
   localparam logic [10:0] SAVE1_X_HI  = 11'(4 * BRICK);
   localparam logic [10:0] SAVE1_FLOOR = 11'(20 * BRICK);
   localparam logic [10:0] SAVE2_X_LO  = 11'(28 * BRICK);
   localparam logic [10:0] SAVE2_X_HI  = 11'(29 * BRICK);
   localparam logic [10:0] SAVE2_FLOOR = 11'(15 * BRICK);
   localparam logic [10:0] EXIT_COL    = 11'(EXIT_X);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEATH_FRAMES - 1);

   logic             frame_s1_q, frame_s2_q, frame_prev_q, tick_q;
   logic             start_prev_q;
   logic [2:0]       state_q, state_d;
   logic [1:0]       ret_q, ret_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       saved_q, saved_d;
   logic [7:0]       death_q, death_d;
   logic [1:0]       level_q, level_d;
   logic [1:0]       bg_q, bg_d;
   logic [9:0]       sx_q, sx_d;
   logic [9:0]       sy_q, sy_d;
   logic             respawn_q, respawn_d;
   logic             eng_q, eng_d;

   logic [10:0] x_ext;
   logic [10:0] feet_y;
   logic        in_save1, in_save2, at_exit, start_rise;

   // Frame strobe crosses into Clk, then becomes a one-cycle registered tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_s1_q   <= 1'b0;
         frame_s2_q   <= 1'b0;
         frame_prev_q <= 1'b0;
         tick_q       <= 1'b0;
      end else begin
         frame_s1_q   <= frame_clk;
         frame_s2_q   <= frame_s1_q;
         frame_prev_q <= frame_s2_q;
         tick_q       <= frame_s2_q & ~frame_prev_q;
      end
   end

   // Feet position is widened so a sprite near the bottom edge cannot wrap.
   assign x_ext      = {1'b0, mario_pos_x};
   assign feet_y     = 11'(mario_pos_y) + 11'(MARIO_H);
   assign in_save1   = (x_ext >= SAVE1_X_LO) && (x_ext < SAVE1_X_HI) && (feet_y >= SAVE1_FLOOR);
   assign in_save2   = (x_ext >= SAVE2_X_LO) && (x_ext < SAVE2_X_HI) && (feet_y >= SAVE2_FLOOR);
   assign at_exit    = (x_ext >= EXIT_COL);
   assign start_rise = start_key & ~start_prev_q;

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      cnt_d     = cnt_q;
      saved_d   = saved_q;
      death_d   = death_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      level_d   = LVL_TITLE;
      bg_d      = 2'd0;
      respawn_d = 1'b0;
      eng_d     = 1'b0;

      case (state_q)
         S_TITLE: begin
            if (start_rise) begin
               saved_d = 2'b00;
               ret_d   = LVL_1;
               state_d = S_RESPAWN;
            end
         end
         S_PLAY1: begin
            if (mario_dead) begin
               state_d = S_DEATH;
            end else begin
               if (in_save1) saved_d[0] = 1'b1;
               if (at_exit) begin
                  ret_d   = LVL_2;
                  state_d = S_RESPAWN;
               end
            end
         end
         S_PLAY2: begin
            if (mario_dead) begin
               state_d = S_DEATH;
            end else if (in_save2) begin
               saved_d[1] = 1'b1;
            end
         end
         S_DEATH: begin
            if (tick_q) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_RESPAWN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_RESPAWN: begin
            state_d = (ret_q == LVL_1) ? S_PLAY1 : S_PLAY2;
         end
         default: begin
            state_d = S_TITLE;
         end
      endcase

      // Death is counted once, on the cycle the death screen is entered.
      if (state_d == S_DEATH && state_q != S_DEATH) begin
         cnt_d = '0;
         if (death_q != 8'hFF) death_d = death_q + 8'd1;
      end

      if (state_d == S_RESPAWN) begin
         respawn_d = 1'b1;
         eng_d     = 1'b1;
         if (ret_d == LVL_1 && saved_d[0]) begin
            sx_d = SAVE1_X;
            sy_d = SAVE1_Y;
         end else if (ret_d == LVL_2 && saved_d[1]) begin
            sx_d = SAVE2_X;
            sy_d = SAVE2_Y;
         end else begin
            sx_d = HOME_X;
            sy_d = HOME_Y;
         end
      end

      case (state_d)
         S_PLAY1:   level_d = LVL_1;
         S_PLAY2:   level_d = LVL_2;
         S_DEATH:   level_d = LVL_DEATH;
         S_RESPAWN: level_d = ret_d;
         default:   level_d = LVL_TITLE;
      endcase

      if (state_d == S_DEATH) bg_d = 2'd1;
   end

   // Edge flop resets high so a key held through reset must be released first.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         start_prev_q <= 1'b1;
         state_q      <= S_TITLE;
         ret_q        <= LVL_1;
         cnt_q        <= '0;
         saved_q      <= 2'b00;
         death_q      <= 8'd0;
         level_q      <= LVL_TITLE;
         bg_q         <= 2'd0;
         sx_q         <= HOME_X;
         sy_q         <= HOME_Y;
         respawn_q    <= 1'b0;
         eng_q        <= 1'b0;
      end else begin
         start_prev_q <= start_key;
         state_q      <= state_d;
         ret_q        <= ret_d;
         cnt_q        <= cnt_d;
         saved_q      <= saved_d;
         death_q      <= death_d;
         level_q      <= level_d;
         bg_q         <= bg_d;
         sx_q         <= sx_d;
         sy_q         <= sy_d;
         respawn_q    <= respawn_d;
         eng_q        <= eng_d;
      end
   end

   assign level_sel    = level_q;
   assign bg_index     = bg_q;
   assign spawn_x      = sx_q;
   assign spawn_y      = sy_q;
   assign respawn      = respawn_q;
   assign engine_reset = eng_q;
   assign saved        = saved_q;
   assign death_count  = death_q;

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 SHALL have parameter BRICK, default 20, meaning tile size in pixels.
REQ-002 SHALL have parameter DEATH_FRAMES, default 60, meaning death-screen hold time in frames.
REQ-003 SHALL have parameter EXIT_X, default 620, meaning level-1 exit column in pixels.
REQ-004 SHALL have parameter MARIO_H, default 24, meaning Mario sprite height in pixels.
REQ-005 SHALL have port Clk  in  1  system clock; one clock domain.
REQ-006 SHALL have port Reset_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port frame_clk  in  1  vsync-rate frame strobe, asynchronous to Clk.
REQ-008 SHALL have port start_key  in  1  start button, level-sensitive.
REQ-009 SHALL have ports mario_pos_x and mario_pos_y  in  10 each  Mario top-left position in pixels.
REQ-010 SHALL have port mario_dead  in  1  death indication from the collision logic.
REQ-011 SHALL have port level_sel  out  2  draw-engine select: 0 title, 1 level1, 2 level2, 3 death screen.
REQ-012 SHALL have port bg_index  out  2  background select for the draw engines.
REQ-013 SHALL have ports spawn_x and spawn_y  out  10 each  respawn coordinates.
REQ-014 SHALL have port respawn  out  1  single-cycle pulse that loads spawn_x and spawn_y into Mario.
REQ-015 SHALL have port engine_reset  out  1  single-cycle pulse that resets the draw engines (moving-spine state).
REQ-016 SHALL have port saved  out  2  save-point flags: bit0 level1, bit1 level2.
REQ-017 SHALL have port death_count  out  8  number of deaths.

Function
REQ-018 SHALL be an FSM with states TITLE, PLAY1, PLAY2, DEATH and RESPAWN, plus a 2-bit ret_level register.
REQ-019 SHALL register every output.
REQ-020 SHALL pass frame_clk through a 2-flop synchronizer and a rising-edge detector; a frame tick is one Clk cycle, 3 cycles after the edge.
REQ-021 SHALL edge-detect start_key on Clk.
REQ-022 TITLE: on a start_key rising edge, SHALL clear saved, set ret_level=1 and go to RESPAWN; otherwise SHALL hold.
REQ-023 PLAY1: mario_dead SHALL go to DEATH; else if mario_pos_x >= EXIT_X, SHALL set ret_level=2 and go to RESPAWN.
REQ-024 PLAY1: mario_dead SHALL win over the exit condition in the same cycle.
REQ-025 PLAY2: mario_dead SHALL go to DEATH; PLAY2 has no exit.
REQ-026 In PLAY states, start_key SHALL be ignored.
REQ-027 DEATH: SHALL increment death_count once on entry, saturating at 255.
REQ-028 DEATH: SHALL count frame ticks from 0; on the DEATH_FRAMES-th tick SHALL go to RESPAWN with ret_level unchanged.
REQ-029 RESPAWN: SHALL last exactly 1 cycle, assert respawn=1 and engine_reset=1, then go to PLAY1 if ret_level=1, else PLAY2.
REQ-030 Spawn table, level1: saved[0]=0 gives (20,336); saved[0]=1 gives (60,376).
REQ-031 Spawn table, level2: saved[1]=0 gives (20,336); saved[1]=1 gives (560,276).
REQ-032 spawn_x and spawn_y SHALL be valid in the same cycle that respawn is high, and SHALL hold between respawns.
REQ-033 Save latch in PLAY1: SHALL set saved[0] when 3*BRICK <= x < 4*BRICK and y+MARIO_H >= 20*BRICK.
REQ-034 Save latch in PLAY2: SHALL set saved[1] when 28*BRICK <= x < 29*BRICK and y+MARIO_H >= 15*BRICK.
REQ-035 y+MARIO_H SHALL be computed at 11 bits so it does not wrap.
REQ-036 Save flags SHALL be sticky until reset or a TITLE start.
REQ-037 A cycle with mario_dead=1 SHALL NOT latch a save.
REQ-038 level_sel SHALL be 0 in TITLE, 1 or 2 in PLAY per level and in RESPAWN per ret_level, and 3 in DEATH.
REQ-039 bg_index SHALL be 1 in DEATH and 0 otherwise.
REQ-040 The transition into a state SHALL be visible on level_sel and bg_index one cycle after the causing input is sampled.

Reset
REQ-041 Reset_n=0 SHALL immediately force state=TITLE, ret_level=1, saved=0, death_count=0, respawn=0, engine_reset=0, level_sel=0, bg_index=0, spawn=(20,336), frame counter=0, and clear synchronizer/edge flops.
REQ-042 Reset asserted mid-DEATH or mid-RESPAWN SHALL abort with no respawn pulse.
REQ-043 After Reset_n rises, a start_key already held high SHALL NOT start the game until it is released and pressed again.

Verification
REQ-044 Reset, start_key pulse -> one RESPAWN cycle with respawn=engine_reset=1, spawn=(20,336), then level_sel=1.
REQ-045 PLAY1, Mario at (65,376) for 1 cycle -> saved=01; then mario_dead -> level_sel=3, bg_index=1, death_count=1; after 60 frame ticks (not before the 60th) -> respawn at (60,376), level_sel=1.
REQ-046 PLAY1, mario_pos_x=620 and mario_dead=1 in the same cycle -> DEATH, not a level change; next cycle x=620 alone after respawn -> RESPAWN with spawn (20,336), then level_sel=2.
REQ-047 PLAY2, Mario at (570,276) -> saved=11; death -> respawn at (560,276); 256 deaths -> death_count holds 255.
REQ-048 Reset_n dropped at DEATH frame 30 -> outputs at reset values asynchronously, no respawn pulse; held start_key across release -> stays TITLE.
